gate_resp_checker: RTL and testbench

Synthesizable self-checking response monitor for two-input gate DUTs. It is the receiving end of the gate stimulus interface. Each clock it samples the applied input pair and the DUT output, then compares the output against a golden model selected at run start. It accumulates vector and error counts, records input-space coverage and the first failing vector, and reports a registered pass/fail verdict after a fixed number of vectors. It sits beside any gate DUT in a bench or on-board self-test wrapper, fed by the stimulus driver.

---
 rtl/gate_resp_checker_if.sv | 27 ++
 rtl/gate_resp_checker.sv | 89 ++++++++
 tb/tb_gate_resp_checker.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gate_resp_checker_if.sv
// gate_resp_checker_if: gate stimulus/response bus; master is the stimulus side, slave is the checker
interface gate_resp_checker_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [2:0]       gate_sel;
  logic             vec_valid;
  logic             in_a;
  logic             in_b;
  logic             dut_o;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       cov;
  logic [1:0]       first_fail_vec;
  logic             first_fail_valid;
  modport master (
    output start, gate_sel, vec_valid, in_a, in_b, dut_o,
    input  busy, done, pass, vec_cnt, err_cnt, cov, first_fail_vec, first_fail_valid
  );
  modport slave (
    input  start, gate_sel, vec_valid, in_a, in_b, dut_o,
    output busy, done, pass, vec_cnt, err_cnt, cov, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: checks a two-input gate DUT against a golden model selected at run start
// Ports: clk; rst_n (synchronous, active-low); bus (slave): start, gate_sel, vec_valid, in_a, in_b, dut_o in;
//   busy, done, pass, vec_cnt, err_cnt, cov, first_fail_vec, first_fail_valid out (all registered).
module gate_resp_checker #(
  parameter int CNT_W   = 8,
  parameter int NUM_VEC = 4
) (
  input logic                clk,
  input logic                rst_n,
  gate_resp_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // Truth table per gate_sel (AND at the low nibble), each nibble indexed by {in_a,in_b}
  localparam logic [31:0] TT = {4'b1100, 4'b0011, 4'b1001, 4'b0110, 4'b0001, 4'b0111, 4'b1110, 4'b1000};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VEC);
  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic [1:0]       ff_q, ff_d;
  logic             ffv_q, ffv_d, pass_q, pass_d, busy_q, done_q;
  logic [1:0]       ab;
  logic             mis;
  assign ab  = {bus.in_a, bus.in_b};
  assign mis = bus.dut_o != TT[{sel_q, ab}];
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    err_d   = err_q;
    cov_d   = cov_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    if (state_q != RUN && bus.start) begin
      state_d = RUN;
      sel_d   = bus.gate_sel;
      vec_d   = '0;
      err_d   = '0;
      cov_d   = '0;
      ff_d    = '0;
      ffv_d   = 1'b0;
      pass_d  = 1'b0;
    end else if (state_q == RUN && bus.vec_valid) begin
      vec_d = &vec_q ? vec_q : vec_q + 1'b1;
      err_d = mis && !(&err_q) ? err_q + 1'b1 : err_q;
      cov_d = cov_q | (4'b0001 << ab);
      ff_d  = mis && !ffv_q ? ab : ff_q;
      ffv_d = ffv_q | mis;
      if (vec_d == LAST) begin
        state_d = DONE;
        pass_d  = err_d == '0 && cov_d == 4'hF;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE;
    end
  end
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.vec_cnt          = vec_q;
  assign bus.err_cnt          = err_q;
  assign bus.cov              = cov_q;
  assign bus.first_fail_vec   = ff_q;
  assign bus.first_fail_valid = ffv_q;
endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: directed and randomized checks of gate_resp_checker against a behavioural model
module tb_gate_resp_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  gate_resp_checker_if #(.CNT_W(8)) if0 ();
  gate_resp_checker_if #(.CNT_W(2)) if1 ();
  gate_resp_checker #(.CNT_W(8), .NUM_VEC(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gate_resp_checker #(.CNT_W(2), .NUM_VEC(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  int n_vec = 0;
  int n_bad = 0;
  // model of the 8-bit / 4-vector instance: mode 0 idle, 1 run, 2 done
  int         m_mode = 0;
  logic [2:0] m_sel = '0;
  int         m_vec = 0;
  int         m_err = 0;
  logic [3:0] m_cov = '0;
  logic [1:0] m_ff = '0;
  logic       m_ffv = 1'b0;
  logic       m_pass = 1'b0;
  function automatic logic gold(input logic [2:0] s, input logic a, input logic b);
    case (s)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction
  // apply one cycle to if0 (called at a negedge), advance the model at the posedge
  task automatic cyc(input logic st, input logic [2:0] sel, input logic vv, input logic a, input logic b,
                     input logic d);
    if0.start = st; if0.gate_sel = sel; if0.vec_valid = vv; if0.in_a = a; if0.in_b = b; if0.dut_o = d;
    @(posedge clk);
    if (!rst_n) begin
      m_mode = 0; m_vec = 0; m_err = 0; m_cov = '0; m_ff = '0; m_ffv = 1'b0; m_pass = 1'b0;
    end else if (m_mode != 1 && st) begin
      m_mode = 1; m_sel = sel; m_vec = 0; m_err = 0; m_cov = '0; m_ff = '0; m_ffv = 1'b0; m_pass = 1'b0;
    end else if (m_mode == 1 && vv) begin
      if (m_vec < 255) m_vec++;
      m_cov[{a, b}] = 1'b1;
      if (d != gold(m_sel, a, b)) begin
        if (m_err < 255) m_err++;
        if (!m_ffv) begin m_ff = {a, b}; m_ffv = 1'b1; end
      end
      if (m_vec == 4) begin m_mode = 2; m_pass = (m_err == 0) && (m_cov == 4'hF); end
    end
    @(negedge clk);
    if0.start = 1'b0; if0.vec_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    if1.start = 1'b1; if1.vec_valid = 1'b1;
    cyc(1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    n_vec++; if (if0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", if0.busy); end
    n_vec++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", if0.done); end
    n_vec++; if (if0.pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %b want 0", if0.pass); end
    n_vec++; if (if0.vec_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_vec got %0d want 0", if0.vec_cnt); end
    n_vec++; if (if0.err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err got %0d want 0", if0.err_cnt); end
    n_vec++; if (if0.cov !== 4'h0) begin n_bad++; $display("FAIL reset_cov got %b want 0000", if0.cov); end
    n_vec++; if ({if0.first_fail_vec, if0.first_fail_valid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ff got %b want 000", {if0.first_fail_vec, if0.first_fail_valid}); end
    n_vec++; if ({if1.busy, if1.done, if1.err_cnt} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_u1 got %b want 0000", {if1.busy, if1.done, if1.err_cnt}); end
    if1.start = 1'b0; if1.vec_valid = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic test_nor_pass();
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if ({if0.busy, if0.done, if0.vec_cnt} !== 10'b10_0000_0000) begin
      n_bad++; $display("FAIL nor_start got busy=%b done=%b vec=%0d want 1 0 0", if0.busy, if0.done, if0.vec_cnt); end
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    n_vec++; if ({if0.vec_cnt, if0.cov} !== {8'd1, 4'b0001}) begin
      n_bad++; $display("FAIL nor_latency got vec=%0d cov=%b want 1 0001", if0.vec_cnt, if0.cov); end
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if (if0.done !== 1'b0) begin n_bad++; $display("FAIL nor_early_done got %b want 0", if0.done); end
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++; if ({if0.busy, if0.done, if0.pass} !== 3'b011) begin
      n_bad++; $display("FAIL nor_verdict got busy,done,pass=%b want 011", {if0.busy, if0.done, if0.pass}); end
    n_vec++; if ({if0.vec_cnt, if0.err_cnt, if0.cov} !== {8'd4, 8'd0, 4'hF}) begin
      n_bad++; $display("FAIL nor_counts got vec=%0d err=%0d cov=%b want 4 0 1111", if0.vec_cnt, if0.err_cnt, if0.cov); end
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++; if ({if0.done, if0.vec_cnt, if0.err_cnt} !== {1'b1, 8'd4, 8'd0}) begin
      n_bad++; $display("FAIL nor_hold got done=%b vec=%0d err=%0d want 1 4 0", if0.done, if0.vec_cnt, if0.err_cnt); end
  endtask
  task automatic test_single_fault();
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if ({if0.busy, if0.done, if0.vec_cnt, if0.cov} !== {2'b10, 8'd0, 4'h0}) begin
      n_bad++; $display("FAIL restart got busy=%b done=%b vec=%0d cov=%b want 1 0 0 0000",
                        if0.busy, if0.done, if0.vec_cnt, if0.cov); end
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++; if ({if0.err_cnt, if0.first_fail_vec, if0.first_fail_valid} !== {8'd1, 2'b11, 1'b1}) begin
      n_bad++; $display("FAIL fault_capture got err=%0d ff=%b ffv=%b want 1 11 1",
                        if0.err_cnt, if0.first_fail_vec, if0.first_fail_valid); end
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++; if ({if0.done, if0.pass, if0.err_cnt} !== {2'b10, 8'd1}) begin
      n_bad++; $display("FAIL fault_verdict got done=%b pass=%b err=%0d want 1 0 1", if0.done, if0.pass, if0.err_cnt); end
  endtask
  task automatic test_cov_hole();
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++; if ({if0.done, if0.pass, if0.err_cnt, if0.cov} !== {2'b10, 8'd0, 4'b1101}) begin
      n_bad++; $display("FAIL cov_hole got done=%b pass=%b err=%0d cov=%b want 1 0 0 1101",
                        if0.done, if0.pass, if0.err_cnt, if0.cov); end
  endtask
  task automatic test_control();
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    n_vec++; if ({if0.busy, if0.vec_cnt} !== {1'b1, 8'd1}) begin
      n_bad++; $display("FAIL gap_stall got busy=%b vec=%0d want 1 1", if0.busy, if0.vec_cnt); end
    // start pulse and gate_sel=4 mid-run; vector 01 gives NOR 0 but XOR 1
    cyc(1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    n_vec++; if ({if0.busy, if0.vec_cnt, if0.err_cnt} !== {1'b1, 8'd2, 8'd0}) begin
      n_bad++; $display("FAIL midrun_start_sel got busy=%b vec=%0d err=%0d want 1 2 0", if0.busy, if0.vec_cnt, if0.err_cnt); end
    rst_n = 1'b0;
    cyc(1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    n_vec++; if ({if0.busy, if0.done, if0.pass, if0.vec_cnt, if0.err_cnt, if0.cov, if0.first_fail_valid} !== 26'd0) begin
      n_bad++; $display("FAIL midrun_reset got busy=%b done=%b vec=%0d cov=%b want all 0",
                        if0.busy, if0.done, if0.vec_cnt, if0.cov); end
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    n_vec++; if ({if0.busy, if0.vec_cnt} !== 9'd0) begin
      n_bad++; $display("FAIL idle_valid got busy=%b vec=%0d want 0 0", if0.busy, if0.vec_cnt); end
    cyc(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    n_vec++; if ({if0.done, if0.pass, if0.vec_cnt} !== {2'b11, 8'd4}) begin
      n_bad++; $display("FAIL rerun got done=%b pass=%b vec=%0d want 1 1 4", if0.done, if0.pass, if0.vec_cnt); end
  endtask
  task automatic test_saturation();
    if1.start = 1'b1; if1.gate_sel = 3'd4;
    @(negedge clk);
    if1.start = 1'b0; if1.gate_sel = 3'd0; if1.vec_valid = 1'b1; if1.dut_o = 1'b1;
    if1.in_a = 1'b0; if1.in_b = 1'b0; @(negedge clk);
    if1.in_a = 1'b1; if1.in_b = 1'b1; @(negedge clk);
    if1.in_a = 1'b0; if1.in_b = 1'b0; @(negedge clk);
    n_vec++; if ({if1.done, if1.pass, if1.vec_cnt, if1.err_cnt} !== 6'b10_11_11) begin
      n_bad++; $display("FAIL sat_counts got done=%b pass=%b vec=%0d err=%0d want 1 0 3 3",
                        if1.done, if1.pass, if1.vec_cnt, if1.err_cnt); end
    n_vec++; if ({if1.cov, if1.first_fail_vec, if1.first_fail_valid} !== 7'b1001_00_1) begin
      n_bad++; $display("FAIL sat_cov_ff got cov=%b ff=%b ffv=%b want 1001 00 1",
                        if1.cov, if1.first_fail_vec, if1.first_fail_valid); end
    if1.in_a = 1'b0; if1.in_b = 1'b1; @(negedge clk);
    n_vec++; if ({if1.err_cnt, if1.cov} !== 6'b11_1001) begin
      n_bad++; $display("FAIL sat_nowrap got err=%0d cov=%b want 3 1001", if1.err_cnt, if1.cov); end
    if1.vec_valid = 1'b0; if1.start = 1'b1; @(negedge clk);
    if1.start = 1'b0;
    n_vec++; if ({if1.busy, if1.done, if1.vec_cnt, if1.err_cnt, if1.cov, if1.first_fail_valid} !== 11'b10_00_00_0000_0) begin
      n_bad++; $display("FAIL sat_restart got busy=%b done=%b vec=%0d err=%0d cov=%b ffv=%b want 1 0 0 0 0000 0",
                        if1.busy, if1.done, if1.vec_cnt, if1.err_cnt, if1.cov, if1.first_fail_valid); end
  endtask
  task automatic test_random();
    logic a, b;
    for (int r = 0; r < 40; r++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; c < 30 && m_mode != 2; c++) begin
        a = 1'($urandom); b = 1'($urandom);
        rst_n = ($urandom % 60) != 0;
        cyc(($urandom % 8) == 0, 3'($urandom), ($urandom % 3) != 0, a, b, gold(m_sel, a, b) ^ (($urandom % 6) == 0));
        rst_n = 1'b1;
        n_vec++;
        if ({if0.busy, if0.done, if0.pass, if0.vec_cnt, if0.err_cnt, if0.cov, if0.first_fail_vec, if0.first_fail_valid}
            !== {m_mode == 1, m_mode == 2, m_pass, 8'(m_vec), 8'(m_err), m_cov, m_ff, m_ffv}) begin
          n_bad++;
          $display("FAIL random run %0d got b%b d%b p%b v%0d e%0d c%b f%b%b want b%b d%b p%b v%0d e%0d c%b f%b%b", r,
                   if0.busy, if0.done, if0.pass, if0.vec_cnt, if0.err_cnt, if0.cov, if0.first_fail_vec, if0.first_fail_valid,
                   m_mode == 1, m_mode == 2, m_pass, m_vec, m_err, m_cov, m_ff, m_ffv);
        end
      end
    end
  endtask
  initial begin
    if0.start = 1'b0; if0.gate_sel = '0; if0.vec_valid = 1'b0; if0.in_a = 1'b0; if0.in_b = 1'b0; if0.dut_o = 1'b0;
    if1.start = 1'b0; if1.gate_sel = '0; if1.vec_valid = 1'b0; if1.in_a = 1'b0; if1.in_b = 1'b0; if1.dut_o = 1'b0;
    @(negedge clk);
    test_reset();
    test_nor_pass();
    test_single_fault();
    test_cov_hole();
    test_control();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
